// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and timing helpers for the HD44780 character-LCD controller.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
   localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] FUNC_SET_BASE = 8'h20;
   localparam logic [7:0] FS_DL         = 8'h10;
   localparam logic [7:0] FS_N          = 8'h08;

   typedef enum logic [2:0] {
      PWR_WAIT  = 3'd0,
      INIT      = 3'd1,
      IDLE      = 3'd2,
      SETUP     = 3'd3,
      E_HIGH    = 3'd4,
      HOLD      = 3'd5,
      EXEC_WAIT = 3'd6
   } state_t;

   function automatic int cycles_per_us(input int clk_hz);
      int c;
      c = clk_hz / 1_000_000;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int us_to_cycles(input int us, input int clk_hz);
      return us * cycles_per_us(clk_hz);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; a state that loads N lasts exactly N cycles (done on the last one).
module lcd_delay_timer
   import lcd_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign done = (count <= W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD controller: power-on init sequencer, valid/ready write port,
// 8- or 4-bit bus, execution delays derived from the clock frequency.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BUS_WIDTH   = 8,
   parameter int NUM_LINES   = 2,
   parameter int POWERUP_US  = 20000,
   parameter int CMD_US      = 50,
   parameter int CLEAR_US    = 1700
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic                 wr_rs,
   input  logic [7:0]           wr_data,
   output logic                 init_done,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_e,
   output logic [BUS_WIDTH-1:0] lcd_data
);

   localparam int US     = cycles_per_us(CLK_FREQ_HZ);
   localparam int MAX_US = (POWERUP_US > CLEAR_US) ? ((POWERUP_US > 4100) ? POWERUP_US : 4100)
                                                   : ((CLEAR_US > 4100) ? CLEAR_US : 4100);
   localparam int TW     = $clog2(MAX_US * US + 1);

   localparam logic [TW-1:0] T_STROBE = TW'(US);
   localparam logic [TW-1:0] T_PWR    = TW'(us_to_cycles(POWERUP_US, CLK_FREQ_HZ));
   localparam logic [TW-1:0] T_CMD    = TW'(us_to_cycles(CMD_US, CLK_FREQ_HZ));
   localparam logic [TW-1:0] T_CLEAR  = TW'(us_to_cycles(CLEAR_US, CLK_FREQ_HZ));
   localparam logic [TW-1:0] T_4100   = TW'(us_to_cycles(4100, CLK_FREQ_HZ));
   localparam logic [TW-1:0] T_100    = TW'(us_to_cycles(100, CLK_FREQ_HZ));

   localparam logic [7:0] WAKE     = FUNC_SET_BASE | FS_DL;
   localparam logic [7:0] FUNC_SET = FUNC_SET_BASE | ((BUS_WIDTH == 8) ? FS_DL : 8'h00)
                                                   | ((NUM_LINES == 2) ? FS_N : 8'h00);
   localparam logic [3:0] LAST_STEP = 4'd8;

   generate
      if (BUS_WIDTH != 8 && BUS_WIDTH != 4) begin : g_bad_bus_width
         $error("lcd_ctrl: BUS_WIDTH must be 8 or 4");
      end
   endgenerate

   // Clear and home need the long execution wait; everything else the short one.
   function automatic logic [TW-1:0] exec_wait(input logic rs, input logic [7:0] b);
      return (!rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03)) ? T_CLEAR : T_CMD;
   endfunction

   // In 4-bit mode the nibble is presented on D7..D4, i.e. the whole narrow bus.
   function automatic logic [BUS_WIDTH-1:0] bus_word(input logic [7:0] b, input logic hi);
      logic [7:0] s;
      s = hi ? b : {b[3:0], 4'h0};
      return s[7 -: BUS_WIDTH];
   endfunction

   state_t          state, state_n;
   logic [3:0]      step;
   logic            in_init;
   logic            init_done_r;
   logic [7:0]      cur_byte;
   logic [TW-1:0]   cur_wait;
   logic            single;
   logic            nib_lo;

   logic            tmr_load, tmr_done;
   logic [TW-1:0]   tmr_val;
   logic            start_init, accept, next_nib, step_adv, finish_init;
   logic [7:0]      init_byte;
   logic [TW-1:0]   init_wait;
   logic            init_single;

   lcd_delay_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .load       (rst | tmr_load),
      .load_value (rst ? T_PWR : tmr_val),
      .done       (tmr_done)
   );

   always_comb begin
      init_byte   = CMD_DISP_ON;
      init_wait   = T_CMD;
      init_single = 1'b0;
      case (step)
         4'd0: begin init_byte = WAKE;          init_wait = T_4100; init_single = 1'b1; end
         4'd1: begin init_byte = WAKE;          init_wait = T_100;  init_single = 1'b1; end
         4'd2: begin init_byte = WAKE;          init_wait = T_CMD;  init_single = 1'b1; end
         4'd3: begin init_byte = FUNC_SET_BASE; init_wait = T_CMD;  init_single = 1'b1; end
         4'd4: begin init_byte = FUNC_SET;      init_wait = exec_wait(1'b0, FUNC_SET); end
         4'd5: begin init_byte = CMD_DISP_OFF;  init_wait = exec_wait(1'b0, CMD_DISP_OFF); end
         4'd6: begin init_byte = CMD_CLEAR;     init_wait = exec_wait(1'b0, CMD_CLEAR); end
         4'd7: begin init_byte = CMD_ENTRY_INC; init_wait = exec_wait(1'b0, CMD_ENTRY_INC); end
         default: ;
      endcase
   end

   always_comb begin
      state_n     = state;
      tmr_load    = 1'b0;
      tmr_val     = T_STROBE;
      start_init  = 1'b0;
      accept      = 1'b0;
      next_nib    = 1'b0;
      step_adv    = 1'b0;
      finish_init = 1'b0;
      case (state)
         PWR_WAIT: if (tmr_done) state_n = INIT;
         INIT: begin
            state_n    = SETUP;
            tmr_load   = 1'b1;
            start_init = 1'b1;
         end
         IDLE: if (wr_valid && init_done_r) begin
            state_n  = SETUP;
            tmr_load = 1'b1;
            accept   = 1'b1;
         end
         SETUP: if (tmr_done) begin
            state_n  = E_HIGH;
            tmr_load = 1'b1;
         end
         E_HIGH: if (tmr_done) begin
            state_n  = HOLD;
            tmr_load = 1'b1;
         end
         HOLD: if (tmr_done) begin
            tmr_load = 1'b1;
            // Low nibble follows immediately; no execution wait between halves.
            if (BUS_WIDTH == 4 && !single && !nib_lo) begin
               state_n  = SETUP;
               next_nib = 1'b1;
            end else begin
               state_n = EXEC_WAIT;
               tmr_val = cur_wait;
            end
         end
         EXEC_WAIT: if (tmr_done) begin
            if (!in_init) begin
               state_n = IDLE;
            end else if (step == LAST_STEP) begin
               state_n     = IDLE;
               finish_init = 1'b1;
            end else begin
               state_n  = INIT;
               step_adv = 1'b1;
            end
         end
         default: state_n = PWR_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PWR_WAIT;
         step        <= 4'd0;
         in_init     <= 1'b1;
         init_done_r <= 1'b0;
         lcd_rs      <= 1'b0;
         lcd_data    <= '0;
      end else begin
         state <= state_n;
         // The lone 4-bit switch nibble is skipped on an 8-bit bus.
         if (step_adv)
            step <= (step == 4'd2 && BUS_WIDTH == 8) ? 4'd4 : step + 4'd1;
         if (finish_init) begin
            init_done_r <= 1'b1;
            in_init     <= 1'b0;
         end
         if (start_init) begin
            lcd_rs   <= 1'b0;
            lcd_data <= bus_word(init_byte, 1'b1);
         end else if (accept) begin
            lcd_rs   <= wr_rs;
            lcd_data <= bus_word(wr_data, 1'b1);
         end else if (next_nib) begin
            lcd_data <= bus_word(cur_byte, 1'b0);
         end
      end
      if (start_init) begin
         cur_byte <= init_byte;
         cur_wait <= init_wait;
         single   <= init_single;
         nib_lo   <= 1'b0;
      end else if (accept) begin
         cur_byte <= wr_data;
         cur_wait <= exec_wait(wr_rs, wr_data);
         single   <= 1'b0;
         nib_lo   <= 1'b0;
      end else if (next_nib) begin
         nib_lo <= 1'b1;
      end
   end

   assign wr_ready  = (state == IDLE) && init_done_r;
   assign init_done = init_done_r;
   assign lcd_e     = (state == E_HIGH);
   assign lcd_rw    = 1'b0;

endmodule
